// File: rtl/udp_tx.sv
// UDP/IPv4/Ethernet frame transmitter onto an 8-bit GMII interface.
// Latches destination and length on tx_start, streams payload via data_req, appends pad, FCS and IFG.
module udp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A,
  parameter logic [15:0] SRC_PORT  = 16'd1234,
  parameter logic [15:0] DST_PORT  = 16'd1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  input  logic [47:0] pc_mac,
  input  logic [31:0] pc_ip,
  output logic        data_req,
  input  logic [7:0]  data_in,
  output logic        gmii_eth_txctl,
  output logic [7:0]  gmii_eth_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS, IFG
  } state_t;

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [47:0] mac_l;
  logic [31:0] ip_l;
  logic [10:0] len_l;
  logic [4:0]  pad_last;
  logic [15:0] ip_id;
  logic [15:0] csum;
  logic [31:0] crc;
  logic [7:0]  byte_n;
  logic        ctl_n;

  logic [10:0] len_c;
  logic [10:0] pad_tmp;
  logic [15:0] ip_tl, udp_len;
  logic [19:0] sum_raw;
  logic [16:0] sum_f1;
  logic [15:0] sum_f2;
  logic [15:0] csum_n;

  logic [111:0] eth_w;
  logic [159:0] ip_w;
  logic [63:0]  udp_w;
  logic [31:0]  fcs_w;
  logic [7:0]   eth_b [0:13];
  logic [7:0]   ip_b  [0:19];
  logic [7:0]   udp_b [0:7];
  logic [7:0]   fcs_b [0:3];

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign len_c   = (tx_len > 16'd1472) ? 11'd1472 : tx_len[10:0];
  assign pad_tmp = 11'd17 - len_c;
  assign ip_tl   = 16'd28 + {5'd0, len_l};
  assign udp_len = 16'd8 + {5'd0, len_l};

  always_comb begin
    sum_raw = {4'd0, 16'h4500} + {4'd0, ip_tl} + {4'd0, ip_id} + {4'd0, 16'h4000}
            + {4'd0, 16'h4011} + {4'd0, BOARD_IP[31:16]} + {4'd0, BOARD_IP[15:0]}
            + {4'd0, ip_l[31:16]} + {4'd0, ip_l[15:0]};
    sum_f1  = {1'b0, sum_raw[15:0]} + {13'd0, sum_raw[19:16]};
    sum_f2  = sum_f1[15:0] + {15'd0, sum_f1[16]};
    csum_n  = ~sum_f2;
  end

  assign eth_w = {mac_l, BOARD_MAC, 16'h0800};
  assign ip_w  = {16'h4500, ip_tl, ip_id, 16'h4000, 8'h40, 8'h11, csum, BOARD_IP, ip_l};
  assign udp_w = {SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign fcs_w = ~crc;

  // Header byte tables, index 0 is the first byte on the wire.
  always_comb begin
    for (int i = 0; i < 14; i++) eth_b[i] = eth_w[8*(13-i) +: 8];
    for (int i = 0; i < 20; i++) ip_b[i]  = ip_w[8*(19-i) +: 8];
    for (int i = 0; i < 8; i++)  udp_b[i] = udp_w[8*(7-i) +: 8];
    for (int i = 0; i < 4; i++)  fcs_b[i] = fcs_w[8*i +: 8];
  end

  // byte_n is the byte that appears on the wire in the next cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 11'd1;
    byte_n  = 8'h00;
    ctl_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 11'd0;
        if (tx_start) begin
          state_n = PREAMBLE;
          cnt_n   = 11'd1;
          byte_n  = 8'h55;
          ctl_n   = 1'b1;
        end
      end
      PREAMBLE: begin
        ctl_n  = 1'b1;
        byte_n = (cnt == 11'd7) ? 8'hD5 : 8'h55;
        if (cnt == 11'd7) begin
          state_n = ETH_HDR;
          cnt_n   = 11'd0;
        end
      end
      ETH_HDR: begin
        ctl_n  = 1'b1;
        byte_n = eth_b[cnt[3:0]];
        if (cnt == 11'd13) begin
          state_n = IP_HDR;
          cnt_n   = 11'd0;
        end
      end
      IP_HDR: begin
        ctl_n  = 1'b1;
        byte_n = ip_b[cnt[4:0]];
        if (cnt == 11'd19) begin
          state_n = UDP_HDR;
          cnt_n   = 11'd0;
        end
      end
      UDP_HDR: begin
        ctl_n  = 1'b1;
        byte_n = udp_b[cnt[2:0]];
        if (cnt == 11'd7) begin
          state_n = (len_l == 11'd0) ? PAD : PAYLOAD;
          cnt_n   = 11'd0;
        end
      end
      PAYLOAD: begin
        ctl_n  = 1'b1;
        byte_n = data_in;
        if (cnt == len_l - 11'd1) begin
          state_n = (len_l < 11'd18) ? PAD : FCS;
          cnt_n   = 11'd0;
        end
      end
      PAD: begin
        ctl_n = 1'b1;
        if (cnt == {6'd0, pad_last}) begin
          state_n = FCS;
          cnt_n   = 11'd0;
        end
      end
      FCS: begin
        ctl_n  = 1'b1;
        byte_n = fcs_b[cnt[1:0]];
        if (cnt == 11'd3) begin
          state_n = IFG;
          cnt_n   = 11'd0;
        end
      end
      IFG: begin
        if (cnt == 11'd11) begin
          state_n = IDLE;
          cnt_n   = 11'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 11'd0;
      mac_l          <= 48'd0;
      ip_l           <= 32'd0;
      len_l          <= 11'd0;
      pad_last       <= 5'd0;
      ip_id          <= 16'd0;
      csum           <= 16'd0;
      crc            <= 32'hFFFF_FFFF;
      gmii_eth_txctl <= 1'b0;
      gmii_eth_txd   <= 8'h00;
      tx_done        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      gmii_eth_txctl <= ctl_n;
      gmii_eth_txd   <= byte_n;
      tx_done        <= (state == IFG) && (cnt == 11'd0);
      if (state == IDLE && tx_start) begin
        mac_l    <= pc_mac;
        ip_l     <= pc_ip;
        len_l    <= len_c;
        pad_last <= pad_tmp[4:0];
      end
      // Latched fields are stable from PREAMBLE on, well ahead of IP byte 10.
      if (state == PREAMBLE) begin
        csum <= csum_n;
        crc  <= 32'hFFFF_FFFF;
      end
      if (state == ETH_HDR || state == IP_HDR || state == UDP_HDR ||
          state == PAYLOAD || state == PAD) begin
        crc <= crc_byte(crc, byte_n);
      end
      if (state == FCS && cnt == 11'd3) begin
        ip_id <= ip_id + 16'd1;
      end
    end
  end

  assign tx_busy  = (state != IDLE);
  assign data_req = ((state == UDP_HDR) && (cnt == 11'd7) && (len_l != 11'd0)) ||
                    ((state == PAYLOAD) && (cnt != len_l - 11'd1));

endmodule

// File: tb/tb_udp_tx.sv
// Bench for udp_tx: spec-derived vector table, reset/busy/back-to-back sequences,
// and random frames compared byte-for-byte with a frame-building reference model.
module tb_udp_tx;

  localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP  = 32'hC0_A8_01_0A;
  localparam logic [15:0] SP   = 16'd1234;
  localparam logic [15:0] DP   = 16'd1234;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [15:0] tx_len;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic        data_req;
  logic [7:0]  data_in;
  logic        gmii_eth_txctl;
  logic [7:0]  gmii_eth_txd;
  logic        tx_busy;
  logic        tx_done;

  udp_tx dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .pc_mac(pc_mac), .pc_ip(pc_ip), .data_req(data_req), .data_in(data_in),
    .gmii_eth_txctl(gmii_eth_txctl), .gmii_eth_txd(gmii_eth_txd),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] pay [0:1471];
  logic [7:0] cap [$];
  logic [7:0] expq [$];
  int  exp_id;
  int  dreq_cnt, dreq_run_max, done_cnt, ctl_cycles, quiet_bad;
  longint first_ctl_t, last_ctl_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int cb(input int i);
    return (i < cap.size()) ? int'(cap[i]) : -1;
  endfunction

  // Reference model: the whole frame as it should appear while txctl is high.
  task automatic build_expected(input int len, input logic [47:0] mac, input logic [31:0] ip, input int id);
    int l, tl, ul;
    logic [7:0] h [0:19];
    logic [31:0] s, c;
    l = (len > 1472) ? 1472 : len;
    tl = 28 + l;
    ul = 8 + l;
    expq.delete();
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < 6; i++) expq.push_back(mac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) expq.push_back(BMAC[8*(5-i) +: 8]);
    expq.push_back(8'h08); expq.push_back(8'h00);
    h[0] = 8'h45; h[1] = 8'h00; h[2] = 8'(tl >> 8); h[3] = 8'(tl);
    h[4] = 8'(id >> 8); h[5] = 8'(id); h[6] = 8'h40; h[7] = 8'h00;
    h[8] = 8'h40; h[9] = 8'h11; h[10] = 8'h00; h[11] = 8'h00;
    for (int i = 0; i < 4; i++) h[12+i] = BIP[8*(3-i) +: 8];
    for (int i = 0; i < 4; i++) h[16+i] = ip[8*(3-i) +: 8];
    s = 0;
    for (int k = 0; k < 10; k++) s = s + {16'd0, h[2*k], h[2*k+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    c = ~s;
    h[10] = c[15:8]; h[11] = c[7:0];
    for (int i = 0; i < 20; i++) expq.push_back(h[i]);
    expq.push_back(SP[15:8]); expq.push_back(SP[7:0]);
    expq.push_back(DP[15:8]); expq.push_back(DP[7:0]);
    expq.push_back(8'(ul >> 8)); expq.push_back(8'(ul));
    expq.push_back(8'h00); expq.push_back(8'h00);
    for (int i = 0; i < l; i++) expq.push_back(pay[i]);
    for (int i = l; i < 18; i++) expq.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < expq.size(); i++) begin
      c = c ^ {24'd0, expq[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) expq.push_back(c[8*i +: 8]);
  endtask

  // Starts at posedge+1 with tx_busy low; returns at posedge+1 with tx_busy low.
  task automatic send_frame(input int len, input logic [47:0] mac, input logic [31:0] ip,
                            input int poke_at, input int abort_at);
    int idx, run, nmis, l;
    bit prev_req, seen_ctl, aborted, timed_out;
    logic [31:0] s;
    l = (len > 1472) ? 1472 : len;
    cap.delete();
    dreq_cnt = 0; dreq_run_max = 0; done_cnt = 0; ctl_cycles = 0; quiet_bad = 0;
    idx = 0; run = 0; prev_req = 0; seen_ctl = 0; aborted = 0; timed_out = 1;
    tx_len = 16'(len); pc_mac = mac; pc_ip = ip; tx_start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        tx_start = 1'b0;
        tx_len = 16'($urandom); pc_mac = {16'($urandom), $urandom}; pc_ip = $urandom;
        chk("first_preamble", {gmii_eth_txctl, gmii_eth_txd}, 9'h155);
      end
      if (cyc == poke_at) begin tx_start = 1'b1; tx_len = 16'd5; end
      if (cyc == poke_at + 1) tx_start = 1'b0;
      if (prev_req) begin
        data_in = (idx < 1472) ? pay[idx] : 8'hXX;
        idx++;
      end
      prev_req = data_req;
      if (gmii_eth_txctl) begin
        cap.push_back(gmii_eth_txd);
        ctl_cycles++;
        if (!seen_ctl) first_ctl_t = longint'($time);
        seen_ctl = 1;
        last_ctl_t = longint'($time);
      end else if (gmii_eth_txd != 8'h00) quiet_bad++;
      if (data_req) begin
        dreq_cnt++; run++;
        if (run > dreq_run_max) dreq_run_max = run;
      end else run = 0;
      if (tx_done) done_cnt++;
      if (cyc == abort_at) begin
        #2 rst = 1'b1;
        #1 chk("reset_midcycle_outputs",
               {gmii_eth_txctl, gmii_eth_txd, data_req, tx_busy, tx_done}, 0);
        repeat (2) begin @(posedge clk); #1; if (tx_done) done_cnt++; end
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (done_cnt > 0 && !tx_busy) begin timed_out = 0; break; end
    end
    if (aborted) begin
      chk("abort_no_done", done_cnt, 0);
      exp_id = 0;
    end else begin
      chk("frame_timeout", timed_out, 0);
      build_expected(len, mac, ip, exp_id);
      chk("frame_len", cap.size(), expq.size());
      nmis = 0;
      for (int i = 0; i < cap.size() && i < expq.size(); i++)
        if (cap[i] !== expq[i]) begin
          if (nmis == 0) $display("FAIL frame_byte[%0d]: got 0x%0h, expected 0x%0h", i, cap[i], expq[i]);
          nmis++;
        end
      chk("frame_byte_mismatches", nmis, 0);
      chk("ip_id", (cb(26) << 8) | cb(27), exp_id);
      s = 0;
      for (int k = 0; k < 10; k++) s = s + 32'((cb(22+2*k) << 8) | cb(23+2*k));
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      chk("ip_hdr_sum", s, 32'hFFFF);
      chk("data_req_count", dreq_cnt, l);
      chk("data_req_consecutive", dreq_run_max, l);
      chk("tx_done_pulses", done_cnt, 1);
      chk("idle_quiet", quiet_bad, 0);
      exp_id = (exp_id + 1) & 16'hFFFF;
    end
  endtask

  task automatic fill_pay_random();
    for (int i = 0; i < 1472; i++) pay[i] = 8'($urandom);
  endtask

  typedef struct {
    int len;
    int txc;
    int dreq;
    int iptl;
    int udpl;
  } vec_t;

  vec_t tbl [0:6];

  initial begin
    longint prev_last;
    int gap, stray;
    logic [31:0] rip;
    logic [47:0] rmac;
    int rlen;

    tbl[0] = '{len: 4,    txc: 72,   dreq: 4,    iptl: 16'h0020, udpl: 16'h000C};
    tbl[1] = '{len: 0,    txc: 72,   dreq: 0,    iptl: 28,       udpl: 8};
    tbl[2] = '{len: 17,   txc: 72,   dreq: 17,   iptl: 45,       udpl: 25};
    tbl[3] = '{len: 18,   txc: 72,   dreq: 18,   iptl: 46,       udpl: 26};
    tbl[4] = '{len: 19,   txc: 73,   dreq: 19,   iptl: 47,       udpl: 27};
    tbl[5] = '{len: 1472, txc: 1526, dreq: 1472, iptl: 1500,     udpl: 1480};
    tbl[6] = '{len: 2000, txc: 1526, dreq: 1472, iptl: 1500,     udpl: 1480};

    rst = 1'b1; tx_start = 1'b0; tx_len = 16'd0; pc_mac = 48'd0; pc_ip = 32'd0; data_in = 8'h00;
    exp_id = 0; first_ctl_t = 0; last_ctl_t = 0;
    #12;
    chk("reset_state", {gmii_eth_txctl, gmii_eth_txd, data_req, tx_busy, tx_done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      fill_pay_random();
      rmac = {16'($urandom), $urandom};
      rip  = $urandom;
      if (v == 0) begin
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        rip = 32'hC0A8_0166;
      end
      send_frame(tbl[v].len, rmac, rip, -1, -1);
      chk("tbl_txctl_cycles", ctl_cycles, tbl[v].txc);
      chk("tbl_data_req", dreq_cnt, tbl[v].dreq);
      chk("tbl_ip_total_len", (cb(24) << 8) | cb(25), tbl[v].iptl);
      chk("tbl_udp_len", (cb(46) << 8) | cb(47), tbl[v].udpl);
    end

    // Abort mid-payload, then a full frame with a busy-time tx_start poke and a back-to-back follower.
    fill_pay_random();
    send_frame(200, 48'hA1A2_A3A4_A5A6, 32'h0A00_0001, -1, 80);
    @(posedge clk); #1;
    send_frame(30, 48'hB1B2_B3B4_B5B6, 32'h0A00_0002, 40, -1);
    chk("post_reset_first_id", (cb(26) << 8) | cb(27), 0);
    prev_last = last_ctl_t;
    send_frame(25, 48'hC1C2_C3C4_C5C6, 32'h0A00_0003, -1, -1);
    chk("second_id", (cb(26) << 8) | cb(27), 1);
    gap = int'((first_ctl_t - prev_last) / 10) - 1;
    chk("ifg_gap_ge_12", (gap >= 12) ? 1 : 0, 1);
    stray = 0;
    repeat (20) begin @(posedge clk); #1; if (gmii_eth_txctl || tx_busy) stray++; end
    chk("no_stray_frame", stray, 0);

    for (int r = 0; r < 6; r++) begin
      fill_pay_random();
      rlen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1600)) : int'($urandom_range(0, 60));
      send_frame(rlen, {16'($urandom), $urandom}, $urandom, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
